// File: rtl/bayer_mosaic_pkg.sv
// Shared types and constants for the Bayer re-mosaic engine.
package bayer_pkg;

    localparam int unsigned IMG_W_LOG2_DEF = 7;
    localparam int unsigned IMG_H_LOG2_DEF = 7;
    localparam int unsigned PIX_W          = 8;
    localparam int unsigned CSUM_W         = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Bayer phase = {row[0], col[0]}
    localparam logic [1:0] PH_G0 = 2'b00;
    localparam logic [1:0] PH_R  = 2'b01;
    localparam logic [1:0] PH_B  = 2'b10;
    localparam logic [1:0] PH_G1 = 2'b11;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } ch_sel_t;

    // Map a Bayer phase to the colour plane that supplies it
    function automatic ch_sel_t phase_to_ch(input logic [1:0] phase);
        ch_sel_t ch;
        case (phase)
            PH_G0, PH_G1: ch = CH_G;
            PH_R:         ch = CH_R;
            PH_B:         ch = CH_B;
            default:      ch = CH_G;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/bayer_mosaic_skid_fifo.sv
// Two-entry pixel FIFO; the head entry is a flop that drives the stream output.
module bayer_skid_fifo
    import bayer_pkg::*;
#(
    parameter int unsigned DATA_W = PIX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occ,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] tail_q;
    logic              head_v;
    logic              tail_v;
    logic              pop_ok;
    logic              push_ok;

    assign pop_ok  = pop & head_v;
    assign push_ok = push & (~tail_v | pop_ok);
    assign occ     = 2'(head_v) + 2'(tail_v);
    assign empty   = ~head_v;
    assign full    = tail_v;

    // Head/tail storage: tail only ever holds data while head is valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head   <= '0;
            tail_q <= '0;
            head_v <= 1'b0;
            tail_v <= 1'b0;
        end else if (clear) begin
            head_v <= 1'b0;
            tail_v <= 1'b0;
        end else if (pop_ok) begin
            if (tail_v) begin
                head <= tail_q;
                if (push_ok) begin
                    tail_q <= push_data;
                end else begin
                    tail_v <= 1'b0;
                end
            end else if (push_ok) begin
                head <= push_data;
            end else begin
                head_v <= 1'b0;
            end
        end else if (push_ok) begin
            if (!head_v) begin
                head   <= push_data;
                head_v <= 1'b1;
            end else begin
                tail_q <= push_data;
                tail_v <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bayer_mosaic.sv
// Re-mosaic engine: streams an R/G/B image out as a raster Bayer pixel stream.
// Optional frame checksum enabled by defining BAYER_MOSAIC_CHECKSUM_EN.
module bayer_mosaic
    import bayer_pkg::*;
#(
    parameter int unsigned IMG_W_LOG2 = IMG_W_LOG2_DEF,
    parameter int unsigned IMG_H_LOG2 = IMG_H_LOG2_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             rd_r,
    output logic                             rd_g,
    output logic                             rd_b,
    output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] addr_r,
    output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] addr_g,
    output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] addr_b,
    input  logic [PIX_W-1:0]                 rdata_r,
    input  logic [PIX_W-1:0]                 rdata_g,
    input  logic [PIX_W-1:0]                 rdata_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [PIX_W-1:0]                 data_out,
    output logic                             done,
    output logic [CSUM_W-1:0]                checksum
);

    localparam int unsigned ADDR_W = IMG_W_LOG2 + IMG_H_LOG2;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    state_t            state;
    logic [CNT_W-1:0]  issue_cnt;
    logic [ADDR_W-1:0] addr_q;
    ch_sel_t           ch_q;

    logic              rd_any;
    logic              pop;
    logic              start_ok;
    logic              fifo_clear;
    logic              fifo_empty;
    logic              fifo_full;
    logic [1:0]        fifo_occ;
    logic [PIX_W-1:0]  push_data;
    logic [2:0]        level;
    logic              all_issued;
    logic              issue;
    logic              do_issue;
    logic              drained;
    logic [ADDR_W-1:0] next_addr;
    ch_sel_t           next_ch;

    assign addr_r    = addr_q;
    assign addr_g    = addr_q;
    assign addr_b    = addr_q;
    assign rd_any    = rd_r | rd_g | rd_b;
    assign out_valid = ~fifo_empty;

    // Per-cycle issue, drain and return-steering decisions
    always_comb begin
        pop        = out_valid & out_ready;
        start_ok   = (state == IDLE) & start;
        fifo_clear = start_ok;
        level      = 3'(fifo_occ) - 3'(pop) + 3'(rd_any);
        all_issued = issue_cnt[ADDR_W];
        issue      = (state == STREAM) & ~all_issued & (level < 3'd2);
        do_issue   = start_ok | issue;
        drained    = (state == STREAM) & all_issued & (level == 3'd0);
        next_addr  = (state == IDLE) ? '0 : issue_cnt[ADDR_W-1:0];
        next_ch    = phase_to_ch({next_addr[IMG_W_LOG2], next_addr[0]});
        case (ch_q)
            CH_R:    push_data = rdata_r;
            CH_B:    push_data = rdata_b;
            default: push_data = rdata_g;
        endcase
    end

    // Control FSM with registered strobes, address, busy and done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            issue_cnt <= '0;
            addr_q    <= '0;
            ch_q      <= CH_G;
            rd_r      <= 1'b0;
            rd_g      <= 1'b0;
            rd_b      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_r <= 1'b0;
            rd_g <= 1'b0;
            rd_b <= 1'b0;
            done <= 1'b0;
            if (do_issue) begin
                addr_q    <= next_addr;
                issue_cnt <= CNT_W'(next_addr) + CNT_W'(1);
                ch_q      <= next_ch;
                rd_r      <= (next_ch == CH_R);
                rd_g      <= (next_ch == CH_G);
                rd_b      <= (next_ch == CH_B);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (drained) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    bayer_skid_fifo #(
        .DATA_W (PIX_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (fifo_clear),
        .push      (rd_any),
        .push_data (push_data),
        .pop       (pop),
        .head      (data_out),
        .occ       (fifo_occ),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // A returning read must always find a free FIFO slot
    assert property (@(posedge clk) disable iff (reset) !(fifo_full & rd_any & ~pop));

`ifdef BAYER_MOSAIC_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q;

    // Wrapping sum of accepted pixels, cleared when a frame starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if (pop) begin
            csum_q <= csum_q + CSUM_W'(data_out);
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_bayer_mosaic.sv
// Self-checking bench for bayer_mosaic with a combinational-read memory model.
module tb_bayer_mosaic;

    localparam int NPIX = 16384;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        rd_r, rd_g, rd_b;
    logic [13:0] addr_r, addr_g, addr_b;
    logic [7:0]  rdata_r, rdata_g, rdata_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  data_out;
    logic        done;
    logic [15:0] checksum;

    // Image content: r[a]=a[7:0], g[a]=~a[7:0], b[a]=a[13:6]
    assign rdata_r = addr_r[7:0];
    assign rdata_g = ~addr_g[7:0];
    assign rdata_b = addr_b[13:6];

    bayer_mosaic dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .rd_r      (rd_r),
        .rd_g      (rd_g),
        .rd_b      (rd_b),
        .addr_r    (addr_r),
        .addr_g    (addr_g),
        .addr_b    (addr_b),
        .rdata_r   (rdata_r),
        .rdata_g   (rdata_g),
        .rdata_b   (rdata_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .done      (done),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: 0=R, 1=G, 2=B for raster pixel i of a 128-wide image
    function automatic int exp_ch(input int i);
        int row0, col0;
        row0 = (i / 128) % 2;
        col0 = i % 2;
        if (row0 == col0) return 1;
        if (col0 == 1) return 0;
        return 2;
    endfunction

    function automatic int exp_pix(input int i);
        case (exp_ch(i))
            0:       return i % 256;
            1:       return 255 - (i % 256);
            default: return (i / 64) % 256;
        endcase
    endfunction

    // Stream observer state
    int     got[$];
    int     ref_q[$];
    logic   mon_en = 1'b0;
    int     n_strobe, n_hs, strobe_err, stall_err, vld_err, max_lvl;
    int     done_cnt, busy_err, cs_zero_err;
    logic   stalled;
    logic [7:0]  stall_data;
    logic [15:0] cs_at_done;
    time    t_start, t_first, t_done;

    task automatic clear_mon();
        got.delete();
        n_strobe = 0; n_hs = 0; strobe_err = 0; stall_err = 0; vld_err = 0;
        max_lvl = 0; done_cnt = 0; busy_err = 0; cs_zero_err = 0;
        stalled = 1'b0; stall_data = 8'h00; cs_at_done = 16'h0;
        t_first = 0; t_done = 0;
    endtask

    // Observe the DUT mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            int lvl;
            int nrd;
            int ch;
            lvl = n_strobe - n_hs;
            if (lvl > max_lvl) max_lvl = lvl;
            if ((lvl > 0) != (out_valid === 1'b1)) vld_err++;
            nrd = int'(rd_r) + int'(rd_g) + int'(rd_b);
            if (nrd > 1) strobe_err++;
            if (nrd == 1) begin
                ch = rd_r ? 0 : (rd_g ? 1 : 2);
                if (addr_r !== addr_g || addr_r !== addr_b ||
                    int'(addr_r) != n_strobe || ch != exp_ch(n_strobe))
                    strobe_err++;
                n_strobe++;
            end
            if (stalled && (out_valid !== 1'b1 || data_out !== stall_data)) stall_err++;
            stalled    = out_valid && !out_ready;
            stall_data = data_out;
            if (out_valid && out_ready) begin
                if (got.size() == 0) t_first = $time;
                got.push_back(int'(data_out));
                n_hs++;
            end
            if (done) begin
                done_cnt++;
                t_done     = $time;
                cs_at_done = checksum;
                if (busy) busy_err++;
            end
`ifndef BAYER_MOSAIC_CHECKSUM_EN
            if (checksum !== 16'h0) cs_zero_err++;
`endif
        end
    end

    typedef struct {
        int idx;
        int val;
    } spot_t;
    spot_t spots[9];

    task automatic check_spots(input string tag);
        for (int k = 0; k < 9; k++) begin
            if (spots[k].idx < got.size())
                check($sformatf("%s_pix%0d", tag, spots[k].idx), got[spots[k].idx], spots[k].val);
            else
                check($sformatf("%s_pix%0d_missing", tag, spots[k].idx), -1, spots[k].val);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_rd"}, int'({rd_r, rd_g, rd_b}), 0);
        check({tag, "_addr"}, int'(addr_r | addr_g | addr_b), 0);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_data"}, int'(data_out), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_csum"}, int'(checksum), 0);
    endtask

    task automatic compare_ref(input string tag);
        int d;
        d = 0;
        if (got.size() != ref_q.size()) d = NPIX + 1;
        else for (int i = 0; i < got.size(); i++) if (got[i] != ref_q[i]) d++;
        check({tag, "_vs_ref"}, d, 0);
    endtask

    task automatic verify(input int mode, input string tag);
        int nmis;
        int sum;
        nmis = 0;
        sum  = 0;
        for (int i = 0; i < got.size(); i++) if (i >= NPIX || got[i] != exp_pix(i)) nmis++;
        for (int i = 0; i < NPIX; i++) sum = (sum + exp_pix(i)) % 65536;
        check({tag, "_pixels"}, got.size(), NPIX);
        check({tag, "_mismatch"}, nmis, 0);
        check({tag, "_reads"}, n_strobe, NPIX);
        check({tag, "_strobe_err"}, strobe_err, 0);
        check({tag, "_stall_err"}, stall_err, 0);
        check({tag, "_valid_err"}, vld_err, 0);
        check({tag, "_fifo_le2"}, int'(max_lvl <= 2), 1);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_at_done"}, busy_err, 0);
`ifdef BAYER_MOSAIC_CHECKSUM_EN
        check({tag, "_checksum"}, int'(cs_at_done), sum);
`else
        check({tag, "_checksum_zero"}, cs_zero_err, 0);
`endif
        if (mode == 0) begin
            check({tag, "_first_latency"}, int'((t_first + 5 - t_start) / 10), 2);
            check({tag, "_done_latency"}, int'((t_done + 5 - t_start) / 10), 16386);
        end
    endtask

    // mode 0: out_ready high; mode 1: random backpressure plus a start at cycle 100
    task automatic run_frame(input int mode, input string tag);
        int cyc;
        clear_mon();
        mon_en    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk);
        t_start = $time;
        #1;
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            if (mode == 1) out_ready = ($urandom_range(0, 99) < 80);
            start = (mode == 1 && cyc == 100);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check({tag, "_done_seen"}, int'(done === 1'b1), 1);
        @(negedge clk); #1;
        verify(mode, tag);
    endtask

    initial begin
        int cyc;
        spots[0] = '{0,     'hFF};
        spots[1] = '{1,     'h01};
        spots[2] = '{2,     'hFD};
        spots[3] = '{3,     'h03};
        spots[4] = '{128,   'h02};
        spots[5] = '{129,   'h7E};
        spots[6] = '{255,   'h00};
        spots[7] = '{16256, 'hFE};
        spots[8] = '{16383, 'h00};

        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("por");
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Full-rate frame
        run_frame(0, "full");
        check_spots("full");
        ref_q = got;

        // start during the FINISH cycle must be ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("finish_start_busy", int'(busy), 0);
        check("finish_start_reads", n_strobe, NPIX);

        // Random backpressure with a second start while busy
        run_frame(1, "bp");
        compare_ref("bp");
        repeat (20) @(posedge clk);
        #1;
        check("bp_single_done", done_cnt, 1);

        // Reset after 500 handshakes
        clear_mon();
        mon_en    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (n_hs < 500 && cyc < 2000) begin
            @(negedge clk); #2;
            cyc++;
        end
        check("rst_mid_reached", n_hs, 500);
        reset = 1'b1;
        #1;
        check_idle("rst_mid");
        mon_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_mon();
        mon_en = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("rst_mid_no_done", done_cnt, 0);
        check("rst_mid_no_reads", n_strobe, 0);

        // Restart after reset, then a back-to-back frame
        run_frame(0, "after_rst");
        check_spots("after_rst");
        ref_q = got;
        run_frame(0, "b2b");
        compare_ref("b2b");

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
